// File: rtl/segway_math_pkg.sv
// Shared constants and arithmetic helpers for the Segway wheel-speed pipeline.
package segway_math_pkg;

  localparam int MIN_DUTY    = 'h0A8;
  localparam int LOW_BAND    = 42;
  localparam int LOW_GAIN    = 4;
  localparam int SLEW_STEP   = 'h080;
  localparam int FAST_THRESH = 1536;
  localparam int FAST_CNT    = 4;

  localparam logic [11:0] STEER_MIN = 12'h200;
  localparam logic [11:0] STEER_MAX = 12'hE00;
  localparam logic [11:0] STEER_CTR = 12'h7FF;

  // Clamp x into the signed range of a w-bit word (w well below 32).
  function automatic int sat_w(input int x, input int w);
    int hi;
    int lo;
    int res;
    hi  = (1 <<< (w - 1)) - 1;
    lo  = -(1 <<< (w - 1));
    res = x;
    if (x > hi) begin
      res = hi;
    end else if (x < lo) begin
      res = lo;
    end
    return res;
  endfunction

  // Deadzone shaping: small torques get extra gain, larger ones get the duty offset.
  function automatic int shape_torque(input int t, input logic pwr_up, input int min_duty,
                                      input int low_band, input int low_gain);
    int res;
    if (!pwr_up) begin
      res = 0;
    end else if (t > low_band) begin
      res = t + min_duty;
    end else if (t < -low_band) begin
      res = t - min_duty;
    end else begin
      res = t * low_gain;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_slew_lim.sv
// Per-wheel slew limiter: moves the held speed toward its target by at most one step per
// valid sample, landing exactly once within reach; a power-down sample zeroes it at once.
module seg_slew_lim
  import segway_math_pkg::*;
#(
  parameter int W         = 12,
  parameter int SLEW_STEP = segway_math_pkg::SLEW_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_i,
  input  logic                pwr_up_i,
  input  logic signed [W-1:0] tgt_i,
  output logic signed [W-1:0] cur_o
);

  localparam int W1 = W + 1;
  localparam logic signed [W:0]   StepWide = W1'(SLEW_STEP);
  localparam logic signed [W-1:0] Step     = W'(SLEW_STEP);

  logic signed [W:0]   diff;
  logic signed [W-1:0] cur_q, cur_d;

  // Next speed: clamp the one-bit-wider difference so the step never wraps.
  always_comb begin
    diff = {tgt_i[W-1], tgt_i} - {cur_q[W-1], cur_q};
    if (!pwr_up_i) begin
      cur_d = '0;
    end else if (diff > StepWide) begin
      cur_d = cur_q + Step;
    end else if (diff < -StepWide) begin
      cur_d = cur_q - Step;
    end else begin
      cur_d = tgt_i;
    end
  end

  // Held speed only moves on valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
    end else if (vld_i) begin
      cur_q <= cur_d;
    end
  end

  assign cur_o = cur_q;

endmodule

// File: rtl/segway_math_pipe.sv
// Three-stage wheel-speed pipeline: soft-start scale and steer term, blend/shape/saturate,
// then per-wheel slew limiting and a debounced over-speed flag.
module segway_math_pipe
  import segway_math_pkg::*;
#(
  parameter int W           = 12,
  parameter int MIN_DUTY    = segway_math_pkg::MIN_DUTY,
  parameter int LOW_BAND    = segway_math_pkg::LOW_BAND,
  parameter int LOW_GAIN    = segway_math_pkg::LOW_GAIN,
  parameter int SLEW_STEP   = segway_math_pkg::SLEW_STEP,
  parameter int FAST_THRESH = segway_math_pkg::FAST_THRESH,
  parameter int FAST_CNT    = segway_math_pkg::FAST_CNT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_in,
  input  logic signed [W-1:0] PID_cntrl,
  input  logic [7:0]          ss_tmr,
  input  logic [11:0]         steer_pot,
  input  logic                en_steer,
  input  logic                pwr_up,
  output logic                vld_out,
  output logic signed [W-1:0] lft_spd,
  output logic signed [W-1:0] rght_spd,
  output logic                too_fast
);

  localparam int CntW = $clog2(FAST_CNT + 1);

  // Stage 1 signals
  logic signed [W+8:0] pid_ext, ss_ext, prod;
  logic [11:0]         pot_clip;
  logic signed [12:0]  steer_val;
  logic signed [W-1:0] pid_ss_d, steer_sc_d;
  logic                vld1_q, en_steer_q, pwr_up1_q;
  logic signed [W-1:0] pid_ss_q, steer_sc_q;

  // Stage 2 signals
  logic signed [W:0]   steer_ext, lft_sum, rght_sum;
  int                  lft_shp, rght_shp;
  logic signed [W-1:0] lft_tgt_d, rght_tgt_d, lft_tgt_q, rght_tgt_q;
  logic                fast_d, fast_q, vld2_q, pwr_up2_q;

  // Stage 3 signals
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                vld_out_q, too_fast_q;

  // S1: soft-start scaling and centred, clipped steer term.
  always_comb begin
    pid_ext  = {{9{PID_cntrl[W-1]}}, PID_cntrl};
    ss_ext   = {{W{1'b0}}, ss_tmr};
    prod     = pid_ext * ss_ext;
    pid_ss_d = W'(prod >>> 8);
    if (steer_pot < STEER_MIN) begin
      pot_clip = STEER_MIN;
    end else if (steer_pot > STEER_MAX) begin
      pot_clip = STEER_MAX;
    end else begin
      pot_clip = steer_pot;
    end
    steer_val  = $signed({1'b0, pot_clip}) - $signed({1'b0, STEER_CTR});
    steer_sc_d = W'((steer_val >>> 4) + (steer_val >>> 3));
  end

  // S1 registers; data holds on non-valid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q     <= 1'b0;
      pid_ss_q   <= '0;
      steer_sc_q <= '0;
      en_steer_q <= 1'b0;
      pwr_up1_q  <= 1'b0;
    end else begin
      vld1_q <= vld_in;
      if (vld_in) begin
        pid_ss_q   <= pid_ss_d;
        steer_sc_q <= steer_sc_d;
        en_steer_q <= en_steer;
        pwr_up1_q  <= pwr_up;
      end
    end
  end

  // S2: blend, shape and saturate both wheels; over-speed looks at the unsaturated shape.
  always_comb begin
    steer_ext  = en_steer_q ? {steer_sc_q[W-1], steer_sc_q} : '0;
    lft_sum    = {pid_ss_q[W-1], pid_ss_q} + steer_ext;
    rght_sum   = {pid_ss_q[W-1], pid_ss_q} - steer_ext;
    lft_shp    = shape_torque(int'(lft_sum), pwr_up1_q, MIN_DUTY, LOW_BAND, LOW_GAIN);
    rght_shp   = shape_torque(int'(rght_sum), pwr_up1_q, MIN_DUTY, LOW_BAND, LOW_GAIN);
    lft_tgt_d  = W'(sat_w(lft_shp, W));
    rght_tgt_d = W'(sat_w(rght_shp, W));
    fast_d     = (lft_shp > FAST_THRESH) || (rght_shp > FAST_THRESH);
  end

  // S2 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld2_q     <= 1'b0;
      lft_tgt_q  <= '0;
      rght_tgt_q <= '0;
      fast_q     <= 1'b0;
      pwr_up2_q  <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        lft_tgt_q  <= lft_tgt_d;
        rght_tgt_q <= rght_tgt_d;
        fast_q     <= fast_d;
        pwr_up2_q  <= pwr_up1_q;
      end
    end
  end

  seg_slew_lim #(
    .W         (W),
    .SLEW_STEP (SLEW_STEP)
  ) u_slew_lft (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (vld2_q),
    .pwr_up_i (pwr_up2_q),
    .tgt_i    (lft_tgt_q),
    .cur_o    (lft_spd)
  );

  seg_slew_lim #(
    .W         (W),
    .SLEW_STEP (SLEW_STEP)
  ) u_slew_rght (
    .clk      (clk),
    .rst      (rst),
    .vld_i    (vld2_q),
    .pwr_up_i (pwr_up2_q),
    .tgt_i    (rght_tgt_q),
    .cur_o    (rght_spd)
  );

  // S3: saturating run-length of over-threshold samples.
  always_comb begin
    cnt_d = cnt_q;
    if (!pwr_up2_q || !fast_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(FAST_CNT)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // S3 registers: flag is registered alongside the slewed speeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out_q  <= 1'b0;
      cnt_q      <= '0;
      too_fast_q <= 1'b0;
    end else begin
      vld_out_q <= vld2_q;
      if (vld2_q) begin
        cnt_q      <= cnt_d;
        too_fast_q <= (cnt_d == CntW'(FAST_CNT));
      end
    end
  end

  assign vld_out  = vld_out_q;
  assign too_fast = too_fast_q;

endmodule

// File: tb/tb_segway_math_pipe.sv
// Directed plus randomized bench for segway_math_pipe against an integer reference model.
module tb_segway_math_pipe;

  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                vld_in;
  logic signed [W-1:0] PID_cntrl;
  logic [7:0]          ss_tmr;
  logic [11:0]         steer_pot;
  logic                en_steer;
  logic                pwr_up;
  logic                vld_out;
  logic signed [W-1:0] lft_spd;
  logic signed [W-1:0] rght_spd;
  logic                too_fast;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit vld;
    int l;
    int r;
    bit tf;
  } exp_t;

  exp_t pipe_q[$];
  int   shown_l, shown_r;
  bit   shown_tf;
  int   m_cur_l, m_cur_r, m_cnt;

  segway_math_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .vld_in    (vld_in),
    .PID_cntrl (PID_cntrl),
    .ss_tmr    (ss_tmr),
    .steer_pot (steer_pot),
    .en_steer  (en_steer),
    .pwr_up    (pwr_up),
    .vld_out   (vld_out),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .too_fast  (too_fast)
  );

  always #5 clk = ~clk;

  function automatic int m_shape(int t, bit pw);
    if (!pw) return 0;
    if (t > 42) return t + 168;
    if (t < -42) return t - 168;
    return t * 4;
  endfunction

  function automatic int m_sat(int t);
    if (t > 2047) return 2047;
    if (t < -2048) return -2048;
    return t;
  endfunction

  function automatic int m_slew(int cur, int tgt);
    if (tgt - cur > 128) return cur + 128;
    if (tgt - cur < -128) return cur - 128;
    return tgt;
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: evaluate one accepted sample end to end with plain integer arithmetic.
  task automatic model_sample(int pid, int ss, int pot, bit en, bit pw, output exp_t e);
    int pid_ss, clip, sv, sc, l, r, ls, rs;
    bit fast;
    pid_ss = (pid * ss) >>> 8;
    clip   = (pot < 'h200) ? 'h200 : (pot > 'hE00) ? 'hE00 : pot;
    sv     = clip - 'h7FF;
    sc     = (sv >>> 4) + (sv >>> 3);
    l      = pid_ss + (en ? sc : 0);
    r      = pid_ss - (en ? sc : 0);
    ls     = m_shape(l, pw);
    rs     = m_shape(r, pw);
    fast   = (ls > 1536) || (rs > 1536);
    if (!pw) begin
      m_cur_l = 0;
      m_cur_r = 0;
      m_cnt   = 0;
    end else begin
      m_cur_l = m_slew(m_cur_l, m_sat(ls));
      m_cur_r = m_slew(m_cur_r, m_sat(rs));
      m_cnt   = fast ? ((m_cnt < 4) ? m_cnt + 1 : 4) : 0;
    end
    e.vld = 1'b1;
    e.l   = m_cur_l;
    e.r   = m_cur_r;
    e.tf  = (m_cnt == 4);
  endtask

  task automatic model_reset();
    exp_t idle;
    idle = '{vld: 1'b0, l: 0, r: 0, tf: 1'b0};
    m_cur_l  = 0;
    m_cur_r  = 0;
    m_cnt    = 0;
    shown_l  = 0;
    shown_r  = 0;
    shown_tf = 1'b0;
    pipe_q.delete();
    pipe_q.push_back(idle);
    pipe_q.push_back(idle);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_vld_out", vld_out, 0);
    chk("rst_lft_spd", lft_spd, 0);
    chk("rst_rght_spd", rght_spd, 0);
    chk("rst_too_fast", too_fast, 0);
  endtask

  task automatic step(bit v, int pid, int ss, int pot, bit en, bit pw);
    exp_t e;
    vld_in    = v;
    PID_cntrl = W'(pid);
    ss_tmr    = 8'(ss);
    steer_pot = 12'(pot);
    en_steer  = en;
    pwr_up    = pw;
    e = '{vld: 1'b0, l: 0, r: 0, tf: 1'b0};
    if (v) model_sample(pid, ss, pot, en, pw, e);
    pipe_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = pipe_q.pop_front();
    if (e.vld) begin
      shown_l  = e.l;
      shown_r  = e.r;
      shown_tf = e.tf;
    end
    chk("vld_out", vld_out, e.vld);
    chk("lft_spd", lft_spd, shown_l);
    chk("rght_spd", rght_spd, shown_r);
    chk("too_fast", too_fast, shown_tf);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 0, 0, 'h7FF, 1'b0, 1'b1);
  endtask

  initial begin
    logic signed [11:0] rp;
    rst = 1'b1; vld_in = 1'b1; PID_cntrl = '0; ss_tmr = '0; steer_pot = 12'h7FF;
    en_steer = 1'b0; pwr_up = 1'b1;
    @(negedge clk);
    do_reset();

    // Step response: 0x080, 0x100, 0x180, then 0x1A7.
    repeat (6) step(1'b1, 'h100, 'hFF, 'h7FF, 1'b0, 1'b1);
    idle(3);
    chk("step_final_lft", lft_spd, 'h1A7);
    chk("step_final_rght", rght_spd, 'h1A7);

    // Power drop zeroes immediately, then re-slews from zero.
    step(1'b1, 'h100, 'hFF, 'h7FF, 1'b0, 1'b0);
    idle(2);
    chk("pwr_drop_lft", lft_spd, 0);
    chk("pwr_drop_tf", too_fast, 0);
    repeat (5) step(1'b1, 'h100, 'hFF, 'h7FF, 1'b0, 1'b1);
    idle(3);
    chk("pwr_back_lft", lft_spd, 'h1A7);

    // Low band, both signs.
    do_reset();
    step(1'b1, 'h014, 'hFF, 'h7FF, 1'b0, 1'b1);
    idle(2);
    chk("low_band_lft", lft_spd, 'h04C);
    chk("low_band_rght", rght_spd, 'h04C);
    do_reset();
    step(1'b1, -'h014, 'hFF, 'h7FF, 1'b0, 1'b1);
    idle(2);

    // Steer only, pot clipped high.
    do_reset();
    repeat (4) step(1'b1, 0, 'hFF, 'hFFF, 1'b1, 1'b1);
    idle(2);
    chk("steer_lft", lft_spd, 'h1C8);
    chk("steer_rght", rght_spd, -'h1C8);

    // Over-speed: saturation, debounce, single-sample clear.
    do_reset();
    repeat (5) step(1'b1, 'h7FF, 'hFF, 'h7FF, 1'b0, 1'b1);
    idle(20);
    chk("fast_tf", too_fast, 1);
    step(1'b1, 'h7FF, 'hFF, 'h7FF, 1'b0, 1'b1);
    step(1'b1, 0, 'hFF, 'h7FF, 1'b0, 1'b1);
    idle(2);
    chk("fast_clear_tf", too_fast, 0);

    // Reset with two samples in flight: neither emerges.
    do_reset();
    repeat (2) step(1'b1, 'h100, 'hFF, 'h7FF, 1'b0, 1'b1);
    do_reset();
    idle(4);

    // Randomized traffic with gaps, steer, power drops.
    repeat (600) begin
      rp = 12'($urandom);
      step($urandom_range(0, 3) != 0, int'(rp), $urandom_range(0, 255),
           $urandom_range(0, 4095), $urandom_range(0, 1) == 1, $urandom_range(0, 15) != 0);
    end
    // Large-torque bursts to exercise the debounce.
    repeat (200) begin
      rp = 12'($urandom_range(1200, 2047));
      step($urandom_range(0, 4) != 0, ($urandom_range(0, 5) == 0) ? 0 : int'(rp), 'hFF,
           $urandom_range(0, 4095), $urandom_range(0, 1) == 1, $urandom_range(0, 20) != 0);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
